// File: rtl/dbg_probe_sampler_if.sv
// Bundle of probe, capture-control and held-sample signals between the core
// debug taps and the overlay-facing sample-and-hold block.
`timescale 1ns/1ps
interface dbg_probe_sampler_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16,
  parameter int DIV_W    = 26,
  parameter int CNT_W    = 16
);
  localparam int TCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] probe_in;
  logic [1:0]                mode;
  logic [DIV_W-1:0]          rate_div;
  logic                      arm;
  logic [TCW-1:0]            trig_chan;
  logic [WIDTH-1:0]          trig_mask;
  logic [WIDTH-1:0]          trig_value;
  logic [CHANNELS*WIDTH-1:0] probe_out;
  logic                      sample_stb;
  logic                      tick;
  logic                      armed;
  logic                      triggered;
  logic [CNT_W-1:0]          sample_count;

  modport master (
    output probe_in, mode, rate_div, arm, trig_chan, trig_mask, trig_value,
    input  probe_out, sample_stb, tick, armed, triggered, sample_count
  );

  modport slave (
    input  probe_in, mode, rate_div, arm, trig_chan, trig_mask, trig_value,
    output probe_out, sample_stb, tick, armed, triggered, sample_count
  );
endinterface

// File: rtl/dbg_probe_sampler.sv
// Sample-and-hold front end for the debug overlay: captures all probe channels
// in continuous, periodic, triggered single-shot or freeze mode.
`timescale 1ns/1ps
module dbg_probe_sampler #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16,
  parameter int DIV_W    = 26,
  parameter int CNT_W    = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  dbg_probe_sampler_if.slave bus
);
  localparam int PW = CHANNELS * WIDTH;

  localparam logic [1:0] MODE_CONT   = 2'b00;
  localparam logic [1:0] MODE_PER    = 2'b01;
  localparam logic [1:0] MODE_TRIG   = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PW-1:0]    probe_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic [1:0]       state;
  logic [PW-1:0]    probe_out;
  logic             sample_stb;
  logic             armed;
  logic             triggered;
  logic [CNT_W-1:0] sample_count;

  logic [WIDTH-1:0] trig_sel;
  logic             chan_ok;
  logic             match;
  logic             cap;
  logic [1:0]       state_nx;
  logic             armed_nx;
  logic             triggered_nx;

  // Out-of-range channel indices can never fire a trigger.
  assign chan_ok = (32'(bus.trig_chan) < 32'(CHANNELS));

  // Select the registered sample of the trigger channel.
  always_comb begin
    trig_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      trig_sel = (32'(bus.trig_chan) == 32'(k)) ? probe_q[k*WIDTH +: WIDTH] : trig_sel;
    end
  end

  assign match = chan_ok && (((trig_sel ^ bus.trig_value) & bus.trig_mask) == '0);

  // Capture decision and trigger state machine; a mode change overrides everything.
  always_comb begin
    cap          = 1'b0;
    state_nx     = state;
    armed_nx     = armed;
    triggered_nx = triggered;
    if (bus.mode != mode_q) begin
      state_nx     = ST_IDLE;
      armed_nx     = 1'b0;
      triggered_nx = 1'b0;
    end else begin
      case (bus.mode)
        MODE_CONT:   cap = 1'b1;
        MODE_PER:    cap = tick;
        MODE_TRIG: begin
          case (state)
            ST_IDLE, ST_DONE: begin
              if (bus.arm) begin
                state_nx     = ST_ARMED;
                armed_nx     = 1'b1;
                triggered_nx = 1'b0;
              end else begin
                state_nx = state;
              end
            end
            ST_ARMED: begin
              if (match) begin
                cap          = 1'b1;
                state_nx     = ST_DONE;
                armed_nx     = 1'b0;
                triggered_nx = 1'b1;
              end else begin
                state_nx = ST_ARMED;
              end
            end
            default: begin
              state_nx     = ST_IDLE;
              armed_nx     = 1'b0;
              triggered_nx = 1'b0;
            end
          endcase
        end
        MODE_FREEZE: cap = 1'b0;
        default:     cap = 1'b0;
      endcase
    end
  end

  // Input register stage and free-running period divider.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      probe_q <= '0;
      mode_q  <= bus.mode;
      cnt     <= bus.rate_div;
      tick    <= 1'b0;
    end else begin
      probe_q <= bus.probe_in;
      mode_q  <= bus.mode;
      if (cnt == '0) begin
        cnt  <= bus.rate_div;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt - DIV_ONE;
        tick <= 1'b0;
      end
    end
  end

  // Trigger state and status flags.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      triggered <= 1'b0;
    end else begin
      state     <= state_nx;
      armed     <= armed_nx;
      triggered <= triggered_nx;
    end
  end

  // Held samples, capture strobe and saturating capture counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      probe_out    <= '0;
      sample_stb   <= 1'b0;
      sample_count <= '0;
    end else begin
      sample_stb <= cap;
      if (cap) begin
        probe_out <= probe_q;
        if (sample_count != '1) begin
          sample_count <= sample_count + CNT_ONE;
        end
      end
    end
  end

  assign bus.probe_out    = probe_out;
  assign bus.sample_stb   = sample_stb;
  assign bus.tick         = tick;
  assign bus.armed        = armed;
  assign bus.triggered    = triggered;
  assign bus.sample_count = sample_count;

endmodule

// File: doc/dbg_probe_sampler.md
Name: dbg_probe_sampler

Overview:
- Parametrised sample-and-hold front end for the on-screen debug overlay. It captures N probe channels, each WIDTH bits wide, into stable held registers.
- It replaces the fixed slow-clock divider and the direct probe wiring with four capture modes: continuous, periodic, triggered single-shot and freeze.
- It sits in the emu top in the clk_sys domain, between core debug signals and the overlay probe inputs in0..in7.

Parameters:
- CHANNELS, 8, number of probe channels.
- WIDTH, 16, bits per channel.
- DIV_W, 26, width of the period divider.
- CNT_W, 16, width of the sample counter.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- probe_in  in  CHANNELS*WIDTH  raw probes; channel k occupies bits [k*WIDTH +: WIDTH].
- mode  in  2  capture mode: 00 continuous, 01 periodic, 10 triggered, 11 freeze.
- rate_div  in  DIV_W  periodic interval; the period is rate_div+1 cycles.
- arm  in  1  single-cycle pulse that arms the triggered mode.
- trig_chan  in  $clog2(CHANNELS)  channel compared for the trigger.
- trig_mask  in  WIDTH  bits that take part in the trigger compare.
- trig_value  in  WIDTH  trigger compare value.
- probe_out  out  CHANNELS*WIDTH  held samples, same packing as probe_in.
- sample_stb  out  1  one-cycle pulse in the cycle probe_out updates.
- tick  out  1  divider pulse, one cycle per period.
- armed  out  1  trigger is armed and waiting.
- triggered  out  1  sticky flag: a triggered capture has occurred.
- sample_count  out  CNT_W  number of captures, saturating.

Behaviour:
- Reset values: probe_out=0, sample_stb=0, tick=0, armed=0, triggered=0, sample_count=0. Divider cnt loads rate_div. probe_q=0. mode_q=mode.
- Input stage: probe_q <= probe_in every cycle (one register stage). All captures copy probe_q.
- Divider:
  - If cnt==0: cnt<=rate_div and tick<=1. Otherwise cnt<=cnt-1 and tick<=0.
  - rate_div=0 gives tick every cycle.
  - A new rate_div takes effect at the next reload.
  - The divider runs in all modes.
- Mode 00 (continuous): probe_out<=probe_q and sample_stb<=1 every cycle. Latency from probe_in to probe_out is 2 cycles.
- Mode 01 (periodic): in any cycle with tick==1, probe_out<=probe_q and sample_stb<=1. probe_out holds otherwise.
- Mode 10 (triggered) state machine, IDLE -> ARMED -> DONE:
  - IDLE: arm=1 -> ARMED. armed<=1, triggered<=0.
  - ARMED: when chan_ok and ((probe_q[trig_chan] ^ trig_value) & trig_mask)==0, capture all channels, sample_stb<=1, armed<=0, triggered<=1 -> DONE.
  - The match is evaluated starting the cycle after arm. A match on the same cycle as arm is not captured.
  - DONE: arm=1 -> ARMED, triggered<=0, probe_out unchanged until the next capture.
  - arm while already ARMED: ignored.
  - trig_mask=0 matches on the first evaluated cycle.
  - trig_chan >= CHANNELS never matches (chan_ok=0).
- Mode 11 (freeze): probe_out holds, sample_stb=0, arm ignored.
- Mode change (mode != mode_q): state returns to IDLE and armed<=0, triggered<=0. No capture occurs in the change cycle. mode_q<=mode.
- arm in modes other than 10: ignored.
- sample_count: increments in the same cycle sample_stb is asserted and saturates at 2^CNT_W-1. It is cleared only by reset.
- Reset mid-operation: reset wins over every other event in the same cycle; all state returns to reset values.

Test Plan:
- Reset, then mode=00, probe_in ch0=0x1234 at cycle t -> probe_out ch0=0x1234 at t+2, sample_stb high every cycle, sample_count increasing by 1 per cycle.
- mode=01, rate_div=4 -> tick every 5 cycles; probe_out updates only on tick cycles; ch3 ramping by 1 per cycle shows steps of 5.
- mode=10, trig_chan=2, trig_mask=0x00FF, trig_value=0x0042, arm pulse, ch2 ramp 0x0030..0x0050 -> single capture with ch2=0x0042; armed 1->0, triggered=1; no further sample_stb.
- mode=10, arm on the cycle ch2 already matches -> no capture that cycle, capture the next cycle if the match persists. A second arm while armed does not change state.
- mode=11 after capture; change probes; pulse arm -> probe_out unchanged, sample_stb=0. Switch to 10 -> triggered cleared.
- CNT_W=4 build, mode=00 for 20 cycles -> sample_count saturates at 0xF. Assert reset mid-ARMED -> armed=0, probe_out=0 the next cycle.
